alu_result_buffer: RTL and testbench
====================================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 The block SHALL have one parameter, DEPTH, default 4, giving the number of FIFO entries; it SHALL be a power of two and at least 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 clr  input  1  synchronous, active-high reset.
REQ-004 zlo_in  input  32  ALU low result word.
REQ-005 zhi_in  input  32  ALU high result word (remainder or product upper half).
REQ-006 op_in  input  4  ALU ctrl code that produced the result.
REQ-007 in_valid  input  1  producer presents a result this cycle.
REQ-008 in_ready  output  1  buffer can accept a result this cycle.
REQ-009 bus_data  output  32  current 32-bit beat.
REQ-010 bus_hi  output  1  1 = beat carries the HI word, 0 = beat carries the LO word.
REQ-011 bus_last  output  1  current beat is the final beat of its result.
REQ-012 bus_op  output  4  op code of the head result.
REQ-013 bus_valid  output  1  beat valid.
REQ-014 bus_ready  input  1  consumer accepts the beat.
REQ-015 drop_err  output  1  one-cycle pulse when an illegal op is discarded.
REQ-016 occupancy  output  log2(DEPTH)+1  number of stored results.

Function
REQ-017 A push SHALL occur when in_valid=1, in_ready=1 and op_in is in 0000..1011; the entry stores {zhi_in, zlo_in, op_in}.
REQ-018 in_ready SHALL equal (occupancy != DEPTH), computed from registered state only; a push SHALL NOT be accepted when full, even if a pop occurs in the same cycle.
REQ-019 When in_valid=1, in_ready=1 and op_in is 1100..1111, the block SHALL store nothing and SHALL assert drop_err on the next cycle for exactly one cycle.
REQ-020 Wide ops are 0010 (multiply) and 0011 (divide); all other legal ops are narrow.
REQ-021 The serializer SHALL have two states, BEAT_LO and BEAT_HI, and SHALL reset to BEAT_LO.
REQ-022 bus_valid SHALL equal (occupancy != 0); bus_data, bus_hi and bus_op SHALL be 0 when the FIFO is empty.
REQ-023 In BEAT_LO, bus_data SHALL be the head LO word and bus_hi SHALL be 0; in BEAT_HI, bus_data SHALL be the head HI word and bus_hi SHALL be 1.
REQ-024 bus_last SHALL be 1 in BEAT_HI, or in BEAT_LO when the head op is narrow.
REQ-025 A beat handshake (bus_valid and bus_ready) with bus_last=0 SHALL move the serializer BEAT_LO to BEAT_HI without popping.
REQ-026 A beat handshake with bus_last=1 SHALL pop the head and set the serializer to BEAT_LO.
REQ-027 The output SHALL hold bus_data, bus_hi, bus_last and bus_op stable while bus_valid=1 and bus_ready=0.
REQ-028 A simultaneous push and pop with occupancy not equal to DEPTH SHALL leave occupancy unchanged.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 Latency: a result pushed into an empty buffer SHALL appear on bus_valid in the following cycle (one cycle, no bypass).
REQ-031 Narrow results SHALL take one beat and wide results two beats (LO then HI); results SHALL leave in push order.

Reset
REQ-032 When clr=1 at a clock edge, the next state SHALL be: occupancy=0, pointers=0, serializer=BEAT_LO, drop_err=0.
REQ-033 During and immediately after reset, bus_valid=0, bus_data=0, bus_hi=0, bus_op=0, bus_last=0 and in_ready=1.
REQ-034 A reset in BEAT_HI SHALL discard the partially transferred result; no HI beat SHALL follow reset.
REQ-035 clr SHALL take priority over a simultaneous push or pop.
REQ-036 FIFO storage SHALL NOT require reset.

Structure
REQ-037 The op-code constants (ALU_ADD=0000 through ALU_NOT=1011) and an is_wide(op) function SHALL live in a shared package, alu_pkg, which is also used by the ALU.
REQ-038 Storage and pointers SHALL be one sub-module, result_fifo (width 68, depth DEPTH); the serializer FSM and drop logic SHALL stay in alu_result_buffer.

Verification
REQ-039 Push ADD (op 0000) with zlo=0x00000005 while bus_ready=1 -> one beat, bus_data=0x5, bus_hi=0, bus_last=1, one cycle after the push.
REQ-040 Push MUL (op 0010) with zhi=0x00000001, zlo=0x80000000 -> beat 0x80000000 (bus_hi=0, bus_last=0), then beat 0x00000001 (bus_hi=1, bus_last=1).
REQ-041 With bus_ready=0, push 4 results -> in_ready=0 and occupancy=4; a 5th in_valid is not accepted; release bus_ready -> 4 results drain in order.
REQ-042 Push op 1101 -> occupancy unchanged, drop_err high for exactly one cycle.
REQ-043 Hold DIV (op 0011) in BEAT_HI with bus_ready=0, then assert clr -> next cycle bus_valid=0 and occupancy=0; a new ADD then emits its LO beat first.
REQ-044 Full buffer with a pop and in_valid in the same cycle -> the push is refused and occupancy=3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, result entry layout and op classification.
// Used by the ALU datapath and by the result buffer that drains it.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_NOT = 4'b1011;

    localparam int ENTRY_W = 68;

    typedef struct packed {
        logic [31:0] zhi;
        logic [31:0] zlo;
        logic [3:0]  op;
    } alu_entry_t;

    typedef enum logic {
        BEAT_LO = 1'b0,
        BEAT_HI = 1'b1
    } beat_t;

    // Multiply and divide produce a meaningful HI word.
    function automatic logic is_wide(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= ALU_NOT;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Circular result store with wrapping pointers and an occupancy count.
// Storage is not reset; only pointers and count are cleared.
module result_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CAP);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so plain increments wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Buffers ALU results and serializes them onto a 32-bit bus,
// LO beat first, then HI for multiply/divide.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [31:0]            zlo_in,
    input  logic [31:0]            zhi_in,
    input  logic [3:0]             op_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [31:0]            bus_data,
    output logic                   bus_hi,
    output logic                   bus_last,
    output logic [3:0]             bus_op,
    output logic                   bus_valid,
    input  logic                   bus_ready,
    output logic                   drop_err,
    output logic [$clog2(DEPTH):0] occupancy
);

    logic       full;
    logic       empty;
    logic       accept;
    logic       legal;
    logic       push;
    logic       pop;
    logic       beat_done;
    alu_entry_t wentry;
    alu_entry_t head;
    beat_t      state;

    assign in_ready = ~full;
    assign legal    = is_legal(op_in);
    assign accept   = in_valid & in_ready;
    assign push     = accept & legal;
    assign wentry   = '{zhi: zhi_in, zlo: zlo_in, op: op_in};

    result_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .count (occupancy),
        .full  (full),
        .empty (empty)
    );

    // Bus fields are forced to zero when nothing is stored.
    assign bus_valid = ~empty;
    assign bus_hi    = bus_valid & (state == BEAT_HI);
    assign bus_data  = !bus_valid ? '0 : (bus_hi ? head.zhi : head.zlo);
    assign bus_op    = bus_valid ? head.op : '0;
    assign bus_last  = bus_valid & (bus_hi | ~is_wide(head.op));
    assign beat_done = bus_valid & bus_ready;
    assign pop       = beat_done & bus_last;

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= BEAT_LO;
            drop_err <= 1'b0;
        end else begin
            drop_err <= accept & ~legal;
            if (beat_done) begin
                state <= bus_last ? BEAT_LO : BEAT_HI;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: expected beats are queued
// on accepted pushes and compared as the bus presents them.
module tb_alu_result_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] data;
        logic        hi;
        logic        last;
        logic [3:0]  op;
    } beat_s;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] zlo_in = '0;
    logic [31:0] zhi_in = '0;
    logic [3:0]  op_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] bus_data;
    logic        bus_hi;
    logic        bus_last;
    logic [3:0]  bus_op;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic        drop_err;
    logic [2:0]  occupancy;

    int    n_chk = 0;
    int    n_pass = 0;
    beat_s q[$];
    int    occ = 0;
    bit    drop_exp = 0;

    always #5 clk = ~clk;

    alu_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .clr       (clr),
        .zlo_in    (zlo_in),
        .zhi_in    (zhi_in),
        .op_in     (op_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bus_data  (bus_data),
        .bus_hi    (bus_hi),
        .bus_last  (bus_last),
        .bus_op    (bus_op),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .drop_err  (drop_err),
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)",
                      tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        check("in_ready", 32'(in_ready), 32'(occ != DEPTH));
        check("occupancy", 32'(occupancy), 32'(occ));
        check("drop_err", 32'(drop_err), 32'(drop_exp));
        check("bus_valid", 32'(bus_valid), 32'(occ != 0));
        if (occ != 0) begin
            check("bus_data", bus_data, q[0].data);
            check("bus_hi", 32'(bus_hi), 32'(q[0].hi));
            check("bus_last", 32'(bus_last), 32'(q[0].last));
            check("bus_op", 32'(bus_op), 32'(q[0].op));
        end else begin
            check("bus_data_idle", bus_data, 32'h0);
            check("bus_hi_idle", 32'(bus_hi), 32'h0);
            check("bus_last_idle", 32'(bus_last), 32'h0);
            check("bus_op_idle", 32'(bus_op), 32'h0);
        end
    endtask

    // One cycle: drive at negedge, update model at posedge, check at next negedge.
    task automatic tick(input bit v, input logic [3:0] op,
                        input logic [31:0] lo, input logic [31:0] hi,
                        input bit rdy);
        bit acc, lgl, hs, pp, wide;
        in_valid  = v;
        op_in     = op;
        zlo_in    = lo;
        zhi_in    = hi;
        bus_ready = rdy;
        acc  = v && (occ != DEPTH);
        lgl  = (op < 4'd12);
        wide = (op == 4'd2) || (op == 4'd3);
        hs   = (occ != 0) && rdy;
        pp   = hs && q[0].last;
        @(posedge clk);
        if (hs) void'(q.pop_front());
        if (pp) occ--;
        if (acc && lgl) begin
            occ++;
            q.push_back('{data: lo, hi: 1'b0, last: !wide, op: op});
            if (wide) q.push_back('{data: hi, hi: 1'b1, last: 1'b1, op: op});
        end
        drop_exp = acc && !lgl;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick(0, 4'd0, '0, '0, rdy);
    endtask

    task automatic do_reset();
        clr       = 1'b1;
        in_valid  = 1'b1;
        op_in     = 4'd0;
        zlo_in    = 32'hdead_beef;
        bus_ready = 1'b1;
        @(posedge clk);
        occ = 0;
        q.delete();
        drop_exp = 0;
        @(negedge clk);
        check_outputs();
        clr      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        do_reset();
        check_outputs();

        // Single narrow result, one cycle latency.
        tick(1, 4'b0000, 32'h5, 32'h0, 1);
        check("add_data", bus_data, 32'h5);
        check("add_last", 32'(bus_last), 32'h1);
        idle(2, 1);

        // Wide multiply: LO then HI.
        tick(1, 4'b0010, 32'h8000_0000, 32'h1, 1);
        check("mul_lo", bus_data, 32'h8000_0000);
        tick(0, 4'd0, '0, '0, 1);
        check("mul_hi", bus_data, 32'h1);
        check("mul_hi_flag", 32'(bus_hi), 32'h1);
        idle(2, 1);

        // Fill with consumer stalled, then a refused 5th push.
        tick(1, 4'b0000, 32'h11, 32'h0, 0);
        tick(1, 4'b0011, 32'h22, 32'h23, 0);
        tick(1, 4'b0101, 32'h33, 32'h0, 0);
        tick(1, 4'b0010, 32'h44, 32'h45, 0);
        check("full_ready", 32'(in_ready), 32'h0);
        check("full_occ", 32'(occupancy), 32'd4);
        tick(1, 4'b0001, 32'h55, 32'h0, 0);
        check("refused_occ", 32'(occupancy), 32'd4);
        idle(8, 1);

        // Illegal op is dropped with a one-cycle pulse.
        tick(1, 4'b1101, 32'h66, 32'h0, 1);
        check("drop_pulse", 32'(drop_err), 32'h1);
        idle(1, 1);
        check("drop_clear", 32'(drop_err), 32'h0);

        // Reset while holding the HI beat of a divide.
        tick(1, 4'b0011, 32'h77, 32'h78, 0);
        tick(0, 4'd0, '0, '0, 1);
        tick(0, 4'd0, '0, '0, 0);
        check("div_held_hi", 32'(bus_hi), 32'h1);
        do_reset();
        check("rst_valid", 32'(bus_valid), 32'h0);
        tick(1, 4'b0000, 32'h99, 32'h0, 0);
        check("post_rst_lo", 32'(bus_hi), 32'h0);
        idle(2, 1);

        // Full plus pop plus in_valid: push refused, occupancy drops to 3.
        for (int i = 0; i < DEPTH; i++) tick(1, 4'b0100, 32'(i), 32'h0, 0);
        tick(1, 4'b0001, 32'haa, 32'h0, 1);
        check("full_pop_occ", 32'(occupancy), 32'd3);
        idle(5, 1);

        // Random traffic exercises wrap and stalls.
        for (int i = 0; i < 300; i++)
            tick($urandom_range(0, 1), 4'($urandom_range(0, 15)),
                 $urandom, $urandom, $urandom_range(0, 3) != 0);
        idle(10, 1);
        check("drained", 32'(occupancy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
